// File: rtl/tdm_demultiplexer_4ch.sv
// tdm_demultiplexer_4ch
// Receive end of a 4-channel TDM lane. A frame-sync marker tags slot 0. An
// internal slot counter regenerates the channel select and steers each beat
// into a shadow register. A complete frame is published on dout as one
// registered parallel word, so dout is never partially updated.
// Optional feature macro: TDM_DEMUX_PARITY_EN adds even parity on din
// (din_par) and a par_err pulse that replaces dout_valid for a bad frame.
module tdm_demultiplexer_4ch #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   din,
    input  logic               din_valid,
    input  logic               frame_sync,
`ifdef TDM_DEMUX_PARITY_EN
    input  logic               din_par,
    output logic               par_err,
`endif
    output logic [4*WIDTH-1:0] dout,
    output logic               dout_valid,
    output logic [1:0]         slot,
    output logic               locked,
    output logic               sync_err
);

    localparam logic [0:0] HUNT = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] sh0;
    logic [WIDTH-1:0] sh1;
    logic [WIDTH-1:0] sh2;
    logic             last_beat;
    logic             frame_ok;

    // Final beat of a properly aligned frame: slot 3 with no sync marker.
    assign last_beat = din_valid && (state == RUN) && !frame_sync && (slot == 2'd3);
    assign locked    = (state == RUN);

`ifdef TDM_DEMUX_PARITY_EN
    logic frame_bad;
    logic beat_bad;

    assign beat_bad = ^{din, din_par};
    assign frame_ok = !(frame_bad || beat_bad);

    // Accumulate parity errors across the frame; a bad frame pulses par_err at slot 3.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_bad <= 1'b0;
            par_err   <= 1'b0;
        end else begin
            par_err <= 1'b0;
            if (din_valid) begin
                if (frame_sync) begin
                    frame_bad <= beat_bad;
                end else if ((state == RUN) && (slot != 2'd0)) begin
                    frame_bad <= frame_bad || beat_bad;
                end
            end
            if (last_beat && !frame_ok) begin
                par_err <= 1'b1;
            end
        end
    end
`else
    assign frame_ok = 1'b1;
`endif

    // Alignment FSM, slot counter, shadow capture and frame publication.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= HUNT;
            slot       <= 2'd0;
            sh0        <= '0;
            sh1        <= '0;
            sh2        <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            sync_err   <= 1'b0;
            if (din_valid) begin
                if (state == HUNT) begin
                    if (frame_sync) begin
                        sh0   <= din;
                        slot  <= 2'd1;
                        state <= RUN;
                    end
                end else begin
                    if (frame_sync) begin
                        // A sync mid-frame restarts the frame at this beat.
                        if (slot != 2'd0) begin
                            sync_err <= 1'b1;
                        end
                        sh0  <= din;
                        slot <= 2'd1;
                    end else begin
                        case (slot)
                            2'd0: begin
                                sync_err <= 1'b1;
                                state    <= HUNT;
                                slot     <= 2'd0;
                            end
                            2'd1: begin
                                sh1  <= din;
                                slot <= 2'd2;
                            end
                            2'd2: begin
                                sh2  <= din;
                                slot <= 2'd3;
                            end
                            default: begin
                                if (frame_ok) begin
                                    dout       <= {din, sh2, sh1, sh0};
                                    dout_valid <= 1'b1;
                                end
                                slot <= 2'd0;
                            end
                        endcase
                    end
                end
            end
        end
    end

endmodule
